window_serializer: RTL

//  Parallel-in, serial-out counterpart of the pixel shift register: accepts one
//  N-sample window (bits*N wide) and streams its samples one per beat over a

---
 rtl/window_serializer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/window_serializer.sv
// Window serializer: loads one bits*N window, streams samples oldest-first.
// Optional SER_SKID_EN adds a second window buffer for bubble-free reloads.
module window_serializer #(
  parameter int bits = 8,
  parameter int N    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [bits*N-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [bits-1:0]   out_data,
  output logic              out_last
);

  if (N < 2) begin : g_cfg_err
    $error("window_serializer: N must be >= 2");
  end

  localparam int CW = (N < 2) ? 1 : $clog2(N);
  localparam logic [CW-1:0] LastIdx = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [bits*N-1:0]   r_data, w_data_nxt;
  logic [bits-1:0]     r_out_data;
  logic                r_out_last;
  logic [bits-1:0]     w_slice;
  logic                w_load;
  logic                w_beat;
  logic                w_done;

`ifdef SER_SKID_EN
  logic [bits*N-1:0]   r_buf, w_buf_nxt;
  logic                r_pend, w_pend_nxt;

  assign in_ready = !r_pend;
`else
  assign in_ready = (r_state == IDLE);
`endif

  assign w_load    = in_valid && in_ready;
  assign w_beat    = (r_state == SHIFT) && out_ready;
  assign w_done    = w_beat && (r_cnt == '0);
  assign out_valid = (r_state == SHIFT);
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
`ifdef SER_SKID_EN
    w_buf_nxt   = r_buf;
    w_pend_nxt  = r_pend;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_load) begin
          w_data_nxt  = in_data;
          w_cnt_nxt   = LastIdx;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
`ifdef SER_SKID_EN
        if (w_done) begin
          // Buffered window takes over on the same edge as the last beat.
          if (r_pend) begin
            w_data_nxt = r_buf;
            w_cnt_nxt  = LastIdx;
            w_pend_nxt = 1'b0;
          end else if (w_load) begin
            w_data_nxt = in_data;
            w_cnt_nxt  = LastIdx;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          if (w_beat) w_cnt_nxt = r_cnt - 1'b1;
          if (w_load) begin
            w_buf_nxt  = in_data;
            w_pend_nxt = 1'b1;
          end
        end
`else
        if (w_done) w_state_nxt = IDLE;
        else if (w_beat) w_cnt_nxt = r_cnt - 1'b1;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_slice = w_data_nxt[bits*int'(w_cnt_nxt) +: bits];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_data     <= '0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_data     <= w_data_nxt;
      r_out_data <= (w_state_nxt == SHIFT) ? w_slice : '0;
      r_out_last <= (w_state_nxt == SHIFT) && (w_cnt_nxt == '0);
    end
  end

`ifdef SER_SKID_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf  <= '0;
      r_pend <= 1'b0;
    end else begin
      r_buf  <= w_buf_nxt;
      r_pend <= w_pend_nxt;
    end
  end
`endif

endmodule
